// File: rtl/demux14_4b.sv
// Four-way 4-bit demultiplexer with valid/ready handshake and a 2-entry FIFO per lane.
// The input lane is chosen by an explicit select or by a round-robin pointer that advances on each accepted push.
module demux14_4b (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] select,
    input  logic       mode,
    output logic [3:0] out0,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3,
    output logic       out0_valid,
    output logic       out1_valid,
    output logic       out2_valid,
    output logic       out3_valid,
    input  logic       out0_ready,
    input  logic       out1_ready,
    input  logic       out2_ready,
    input  logic       out3_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } lane_state_e;

    lane_state_e r_state     [4];
    lane_state_e w_state_nxt [4];
    logic [3:0]  r_mem       [4][2];
    logic [3:0]  r_wptr;
    logic [3:0]  r_rptr;
    logic [1:0]  r_rr_ptr;

    logic [1:0]  w_dest;
    logic        w_push;
    logic [3:0]  w_full;
    logic [3:0]  w_valid;
    logic [3:0]  w_push_lane;
    logic [3:0]  w_pop;
    logic [3:0]  w_out_ready;
    logic [3:0]  w_head [4];

    assign w_out_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

    // Destination lane, readiness and per-lane push/pop strobes.
    always_comb begin
        w_dest = mode ? r_rr_ptr : select;
        for (int k = 0; k < 4; k++) begin
            w_full[k]  = (r_state[k] == ST_FULL);
            w_valid[k] = (r_state[k] != ST_EMPTY);
        end
        in_ready = ~w_full[w_dest];
        w_push   = in_valid & in_ready;
        for (int k = 0; k < 4; k++) begin
            w_push_lane[k] = w_push & (w_dest == 2'(k));
            w_pop[k]       = w_valid[k] & w_out_ready[k];
        end
    end

    // Per-lane occupancy FSM; a FULL lane never sees a push because in_ready is low for it.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                ST_EMPTY: begin
                    if (w_push_lane[k]) begin
                        w_state_nxt[k] = ST_ONE;
                    end else begin
                        w_state_nxt[k] = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    case ({w_push_lane[k], w_pop[k]})
                        2'b10:   w_state_nxt[k] = ST_FULL;
                        2'b01:   w_state_nxt[k] = ST_EMPTY;
                        default: w_state_nxt[k] = ST_ONE;
                    endcase
                end
                ST_FULL: begin
                    if (w_pop[k]) begin
                        w_state_nxt[k] = ST_ONE;
                    end else begin
                        w_state_nxt[k] = ST_FULL;
                    end
                end
                default: w_state_nxt[k] = ST_EMPTY;
            endcase
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= ST_EMPTY;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= w_state_nxt[k];
            end
        end
    end

    // Lane storage and 1-bit read/write pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[k][0] <= 4'b0000;
                r_mem[k][1] <= 4'b0000;
            end
            r_wptr <= 4'b0000;
            r_rptr <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_push_lane[k]) begin
                    r_mem[k][r_wptr[k]] <= in;
                    r_wptr[k]           <= ~r_wptr[k];
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= ~r_rptr[k];
                end
            end
        end
    end

    // Round-robin pointer advances only on a push accepted in round-robin mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_push && mode) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    // Head-of-lane data, forced to zero while the lane is empty.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (w_valid[k]) begin
                w_head[k] = r_mem[k][r_rptr[k]];
            end else begin
                w_head[k] = 4'b0000;
            end
        end
    end

    assign out0       = w_head[0];
    assign out1       = w_head[1];
    assign out2       = w_head[2];
    assign out3       = w_head[3];
    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out2_valid = w_valid[2];
    assign out3_valid = w_valid[3];

endmodule

// File: tb/tb_demux14_4b.sv
// Self-checking bench for demux14_4b: directed scenarios then random traffic,
// all compared against a queue-based reference model of the four lanes.
module tb_demux14_4b;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] select;
    logic       mode;
    logic [3:0] ordy;
    logic [3:0] out0, out1, out2, out3;
    logic       out0_valid, out1_valid, out2_valid, out3_valid;

    logic [3:0] q [4][$];
    int         rr;
    int         vectors     = 0;
    int         miscompares = 0;

    demux14_4b dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (select),
        .mode       (mode),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .out0_valid (out0_valid),
        .out1_valid (out1_valid),
        .out2_valid (out2_valid),
        .out3_valid (out3_valid),
        .out0_ready (ordy[0]),
        .out1_ready (ordy[1]),
        .out2_ready (ordy[2]),
        .out3_ready (ordy[3])
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dut_out(int k);
        case (k)
            0:       return out0;
            1:       return out1;
            2:       return out2;
            default: return out3;
        endcase
    endfunction

    function automatic logic dut_valid(int k);
        case (k)
            0:       return out0_valid;
            1:       return out1_valid;
            2:       return out2_valid;
            default: return out3_valid;
        endcase
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), 8'(dut_valid(k)), 8'(q[k].size() > 0));
            chk($sformatf("%s_data%0d", tag, k), 8'(dut_out(k)),
                (q[k].size() > 0) ? 8'(q[k][0]) : 8'h00);
        end
    endtask

    // One clock: check in_ready, apply the edge to the model, check all lanes.
    task automatic cycle(string tag);
        int d;
        bit rdy;
        #1;
        d   = mode ? rr : int'(select);
        rdy = (q[d].size() < 2);
        chk({tag, "_in_ready"}, 8'(in_ready), 8'(rdy));
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() > 0 && ordy[k]) void'(q[k].pop_front());
        end
        if (in_valid && rdy) begin
            q[d].push_back(in);
            if (mode) rr = (rr + 1) % 4;
        end
        #1;
        check_outs(tag);
    endtask

    task automatic push(string tag, logic [3:0] v);
        in       = v;
        in_valid = 1'b1;
        cycle(tag);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        ordy     = 4'hF;
        in_valid = 1'b0;
        cycle("drain");
        cycle("drain");
    endtask

    initial begin
        reset = 1'b0; in = 4'h0; in_valid = 1'b0; select = 2'd0; mode = 1'b0; ordy = 4'h0;
        rr = 0;
        #3;
        check_outs("rst");
        chk("rst_in_ready", 8'(in_ready), 8'h01);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed steering into lane 2 until it fills.
        mode = 1'b0; select = 2'd2; ordy = 4'h0;
        push("sel_a", 4'hA);
        chk("sel_out2_a", 8'(out2), 8'h0A);
        chk("sel_out2_valid", 8'(out2_valid), 8'h01);
        push("sel_5", 4'h5);
        chk("sel_full_ready", 8'(in_ready), 8'h00);
        select = 2'd1;
        #1;
        chk("sel_other_ready", 8'(in_ready), 8'h01);
        drain();

        // Round-robin over all lanes with every lane draining.
        mode = 1'b1; ordy = 4'hF;
        for (int v = 1; v <= 5; v++) begin
            push("rr", 4'(v));
            if (v == 1) chk("rr_out0_first", 8'(out0), 8'h01);
            if (v == 5) chk("rr_out0_fifth", 8'(out0), 8'h05);
        end
        ordy = 4'h0;
        push("rr_next", 4'h9);
        chk("rr_ptr_at_1", 8'({out1_valid, out1}), 8'h19);
        drain();

        // Back-pressure: lane 0 full in round-robin mode with rr_ptr at 0.
        push("bp_lane2", 4'h2);
        push("bp_lane3", 4'h3);
        drain();
        mode = 1'b0; select = 2'd0; ordy = 4'h0;
        push("bp_fill", 4'hB);
        push("bp_fill", 4'hD);
        mode = 1'b1; in = 4'h6; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_hold_ready", 8'(in_ready), 8'h00);
        end
        in_valid = 1'b0; ordy = 4'h1;
        cycle("bp_pop");
        ordy = 4'h0;
        #1;
        chk("bp_after_pop_ready", 8'(in_ready), 8'h01);
        push("bp_accept", 4'h6);
        drain();
        drain();

        // Simultaneous push and pop on a lane holding one entry.
        mode = 1'b0; select = 2'd3; ordy = 4'h0;
        push("pp_c", 4'hC);
        ordy = 4'h8;
        push("pp_7", 4'h7);
        chk("pp_out3", 8'({out3_valid, out3}), 8'h17);
        cycle("pp_last");
        chk("pp_count1", 8'(out3_valid), 8'h00);

        // Mode switch: rr_ptr must survive a stretch of select-directed pushes.
        drain();
        mode = 1'b1; ordy = 4'hF;
        push("ms_adv", 4'h4);
        mode = 1'b0; select = 2'd0;
        push("ms_sel", 4'h1);
        push("ms_sel", 4'h2);
        drain();
        mode = 1'b1; ordy = 4'h0;
        push("ms_back", 4'hE);
        chk("ms_lane2", 8'({out2_valid, out2}), 8'h1E);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in       = 4'($urandom_range(0, 15));
            in_valid = ($urandom_range(0, 3) != 0);
            select   = 2'($urandom_range(0, 3));
            mode     = 1'($urandom_range(0, 1));
            ordy     = 4'($urandom_range(0, 15));
            cycle("rand");
        end

        // Asynchronous reset in the middle of traffic.
        ordy = 4'h0; mode = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            select = 2'(k);
            in     = 4'(k + 8);
            cycle("pre_rst");
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) q[k].delete();
        rr = 0;
        check_outs("mid_rst");
        chk("mid_rst_in_ready", 8'(in_ready), 8'h01);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mode = 1'b1;
        push("post_rst", 4'h3);
        chk("post_rst_lane0", 8'({out0_valid, out0}), 8'h13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
